// File: rtl/toggle_reg.sv
// Multi-mode WIDTH-bit register: masked toggle, load, inc/dec, clear, hold.
// Flags: one-cycle wrap/saturate carry pulse, sticky overflow, zero detect.
module toggle_reg #(
  parameter int                WIDTH     = 16,
  parameter logic [WIDTH-1:0]  RESET_VAL = '0,
  parameter bit                SATURATE  = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             reg_en,
  input  logic             reg_clr,
  input  logic             reg_ld,
  input  logic             reg_tgl,
  input  logic             reg_inr,
  input  logic             reg_dcr,
  input  logic [WIDTH-1:0] reg_indata,
  output logic [WIDTH-1:0] reg_outdata,
  output logic [WIDTH-1:0] reg_outdata_bar,
  output logic             reg_carry,
  output logic             reg_ovf,
  output logic             reg_zero
);

  localparam logic [WIDTH-1:0] ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  logic [WIDTH-1:0] r_data;
  logic             r_carry;
  logic             r_ovf;

  logic [WIDTH-1:0] w_data_nxt;
  logic             w_carry_nxt;
  logic             w_ovf_nxt;

  always_comb begin
    w_data_nxt  = r_data;
    w_carry_nxt = 1'b0;
    w_ovf_nxt   = r_ovf;
    if (!reg_en) begin
      w_data_nxt = r_data;
    end else if (reg_clr) begin
      w_data_nxt = '0;
      w_ovf_nxt  = 1'b0;
    end else if (reg_ld) begin
      w_data_nxt = reg_indata;
    end else if (reg_tgl) begin
      w_data_nxt = r_data ^ reg_indata;
    end else if (reg_inr && !reg_dcr) begin
      if (r_data == ONES) begin
        // Saturating mode pins at the limit but still reports the event.
        w_data_nxt  = SATURATE ? ONES : '0;
        w_carry_nxt = 1'b1;
        w_ovf_nxt   = 1'b1;
      end else begin
        w_data_nxt = r_data + ONE;
      end
    end else if (reg_dcr && !reg_inr) begin
      if (r_data == '0) begin
        w_data_nxt  = SATURATE ? '0 : ONES;
        w_carry_nxt = 1'b1;
        w_ovf_nxt   = 1'b1;
      end else begin
        w_data_nxt = r_data - ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_data  <= RESET_VAL;
      r_carry <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_data  <= w_data_nxt;
      r_carry <= w_carry_nxt;
      r_ovf   <= w_ovf_nxt;
    end
  end

  assign reg_outdata     = r_data;
  assign reg_outdata_bar = ~r_data;
  assign reg_carry       = r_carry;
  assign reg_ovf         = r_ovf;
  assign reg_zero        = (r_data == '0);

endmodule

// File: tb/tb_toggle_reg.sv
// Directed vector bench for toggle_reg: 4-bit wrap, 4-bit saturate and 1-bit instances.
module tb_toggle_reg;

  typedef struct packed {
    logic       rst;
    logic       en;
    logic       clr;
    logic       ld;
    logic       tgl;
    logic       inr;
    logic       dcr;
    logic [3:0] din;
  } ctl_t;

  typedef struct {
    int         sel;
    ctl_t       ctl;
    logic [3:0] exp_out;
    logic       exp_c;
    logic       exp_o;
    string      name;
  } vec_t;

  localparam ctl_t IDLE = '0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  ctl_t a_ctl = IDLE, b_ctl = IDLE, c_ctl = IDLE;
  logic [3:0] a_out, a_bar, b_out, b_bar;
  logic [0:0] c_out, c_bar;
  logic a_c, a_o, a_z, b_c, b_o, b_z, c_c, c_o, c_z;

  int n_vec = 0;
  int n_bad = 0;
  vec_t vq[$];

  toggle_reg #(.WIDTH(4), .RESET_VAL(4'h5), .SATURATE(1'b0)) u_wrap (
    .clk(clk), .reset(a_ctl.rst), .reg_en(a_ctl.en), .reg_clr(a_ctl.clr),
    .reg_ld(a_ctl.ld), .reg_tgl(a_ctl.tgl), .reg_inr(a_ctl.inr), .reg_dcr(a_ctl.dcr),
    .reg_indata(a_ctl.din), .reg_outdata(a_out), .reg_outdata_bar(a_bar),
    .reg_carry(a_c), .reg_ovf(a_o), .reg_zero(a_z)
  );

  toggle_reg #(.WIDTH(4), .RESET_VAL(4'h5), .SATURATE(1'b1)) u_sat (
    .clk(clk), .reset(b_ctl.rst), .reg_en(b_ctl.en), .reg_clr(b_ctl.clr),
    .reg_ld(b_ctl.ld), .reg_tgl(b_ctl.tgl), .reg_inr(b_ctl.inr), .reg_dcr(b_ctl.dcr),
    .reg_indata(b_ctl.din), .reg_outdata(b_out), .reg_outdata_bar(b_bar),
    .reg_carry(b_c), .reg_ovf(b_o), .reg_zero(b_z)
  );

  toggle_reg #(.WIDTH(1), .RESET_VAL(1'b1), .SATURATE(1'b0)) u_bit (
    .clk(clk), .reset(c_ctl.rst), .reg_en(c_ctl.en), .reg_clr(c_ctl.clr),
    .reg_ld(c_ctl.ld), .reg_tgl(c_ctl.tgl), .reg_inr(c_ctl.inr), .reg_dcr(c_ctl.dcr),
    .reg_indata(c_ctl.din[0:0]), .reg_outdata(c_out), .reg_outdata_bar(c_bar),
    .reg_carry(c_c), .reg_ovf(c_o), .reg_zero(c_z)
  );

  task automatic add(input int sel, input string name,
                     input logic rst, input logic en, input logic clr, input logic ld,
                     input logic tgl, input logic inr, input logic dcr, input logic [3:0] din,
                     input logic [3:0] eo, input logic ec, input logic eov);
    vec_t v;
    v.sel = sel; v.name = name;
    v.ctl = '{rst: rst, en: en, clr: clr, ld: ld, tgl: tgl, inr: inr, dcr: dcr, din: din};
    v.exp_out = eo; v.exp_c = ec; v.exp_o = eov;
    vq.push_back(v);
  endtask

  // Drive one DUT for one edge, leave the others disabled, then check 1 time unit later.
  task automatic apply(input vec_t v);
    logic [3:0] mask, got_out, got_bar, exp_bar;
    logic got_c, got_o, got_z, exp_z;
    a_ctl = IDLE; b_ctl = IDLE; c_ctl = IDLE;
    case (v.sel)
      0: a_ctl = v.ctl;
      1: b_ctl = v.ctl;
      default: c_ctl = v.ctl;
    endcase
    @(posedge clk);
    #1;
    case (v.sel)
      0: begin mask = 4'hF; got_out = a_out; got_bar = a_bar; got_c = a_c; got_o = a_o; got_z = a_z; end
      1: begin mask = 4'hF; got_out = b_out; got_bar = b_bar; got_c = b_c; got_o = b_o; got_z = b_z; end
      default: begin
        mask = 4'h1; got_out = {3'b0, c_out}; got_bar = {3'b0, c_bar};
        got_c = c_c; got_o = c_o; got_z = c_z;
      end
    endcase
    exp_bar = ~v.exp_out & mask;
    exp_z   = (v.exp_out == 4'h0);
    n_vec++;
    if (got_out !== v.exp_out || got_bar !== exp_bar || got_c !== v.exp_c ||
        got_o !== v.exp_o || got_z !== exp_z) begin
      n_bad++;
      $display("FAIL %s: got out=%h bar=%h carry=%b ovf=%b zero=%b, want out=%h bar=%h carry=%b ovf=%b zero=%b",
               v.name, got_out, got_bar, got_c, got_o, got_z,
               v.exp_out, exp_bar, v.exp_c, v.exp_o, exp_z);
    end
  endtask

  initial begin
    //        sel name           rst en clr ld tgl inr dcr din    out  c  o
    add(0, "wrap_reset",      1, 0, 0, 1, 0, 0, 0, 4'hA, 4'h5, 0, 0);
    add(0, "wrap_ld_E",       0, 1, 0, 1, 0, 0, 0, 4'hE, 4'hE, 0, 0);
    add(0, "wrap_inr_F",      0, 1, 0, 0, 0, 1, 0, 4'h0, 4'hF, 0, 0);
    add(0, "wrap_inr_0",      0, 1, 0, 0, 0, 1, 0, 4'h0, 4'h0, 1, 1);
    add(0, "wrap_inr_1",      0, 1, 0, 0, 0, 1, 0, 4'h0, 4'h1, 0, 1);
    add(0, "prio_ld_3",       0, 1, 0, 1, 0, 0, 0, 4'h3, 4'h3, 0, 1);
    add(0, "prio_clr",        0, 1, 1, 1, 1, 1, 0, 4'h9, 4'h0, 0, 0);
    add(0, "prio_ld_tgl",     0, 1, 0, 1, 1, 0, 0, 4'h9, 4'h9, 0, 0);
    add(0, "prio_tgl_inr",    0, 1, 0, 0, 1, 1, 0, 4'h6, 4'hF, 0, 0);
    add(0, "prio_inr_dcr",    0, 1, 0, 0, 0, 1, 1, 4'h0, 4'hF, 0, 0);
    add(0, "b2b_inr_wrap",    0, 1, 0, 0, 0, 1, 0, 4'h0, 4'h0, 1, 1);
    add(0, "b2b_dcr_wrap",    0, 1, 0, 0, 0, 0, 1, 4'h0, 4'hF, 1, 1);
    add(0, "en_ld_7",         0, 1, 0, 1, 0, 0, 0, 4'h7, 4'h7, 0, 1);
    add(0, "en_off_clr",      0, 0, 1, 0, 0, 0, 0, 4'h0, 4'h7, 0, 1);
    add(0, "en_off_ld",       0, 0, 0, 1, 0, 0, 0, 4'h2, 4'h7, 0, 1);
    add(0, "en_off_inr",      0, 0, 0, 0, 0, 1, 0, 4'h2, 4'h7, 0, 1);
    add(0, "en_off_mix",      0, 0, 1, 1, 0, 1, 0, 4'h2, 4'h7, 0, 1);
    add(0, "en_on_inr",       0, 1, 0, 0, 0, 1, 0, 4'h0, 4'h8, 0, 1);
    add(0, "tgl_zero_mask",   0, 1, 0, 0, 1, 0, 0, 4'h0, 4'h8, 0, 1);
    add(0, "tgl_mask_C",      0, 1, 0, 0, 1, 0, 0, 4'hC, 4'h4, 0, 1);
    add(0, "no_ctl_hold",     0, 1, 0, 0, 0, 0, 0, 4'hB, 4'h4, 0, 1);
    add(0, "dcr_plain",       0, 1, 0, 0, 0, 0, 1, 4'h0, 4'h3, 0, 1);
    add(0, "midwrap_ld_F",    0, 1, 0, 1, 0, 0, 0, 4'hF, 4'hF, 0, 1);
    add(0, "midwrap_reset",   1, 1, 0, 0, 0, 1, 0, 4'h0, 4'h5, 0, 0);
    add(0, "after_reset",     0, 1, 0, 0, 0, 0, 0, 4'h0, 4'h5, 0, 0);

    add(1, "sat_reset",       1, 0, 0, 0, 0, 0, 0, 4'h0, 4'h5, 0, 0);
    add(1, "sat_ld_1",        0, 1, 0, 1, 0, 0, 0, 4'h1, 4'h1, 0, 0);
    add(1, "sat_dcr_0",       0, 1, 0, 0, 0, 0, 1, 4'h0, 4'h0, 0, 0);
    add(1, "sat_dcr_pin",     0, 1, 0, 0, 0, 0, 1, 4'h0, 4'h0, 1, 1);
    add(1, "sat_dcr_pin2",    0, 1, 0, 0, 0, 0, 1, 4'h0, 4'h0, 1, 1);
    add(1, "sat_clr",         0, 1, 1, 0, 0, 0, 0, 4'h0, 4'h0, 0, 0);
    add(1, "sat_ld_E",        0, 1, 0, 1, 0, 0, 0, 4'hE, 4'hE, 0, 0);
    add(1, "sat_inr_F",       0, 1, 0, 0, 0, 1, 0, 4'h0, 4'hF, 0, 0);
    add(1, "sat_inr_pin",     0, 1, 0, 0, 0, 1, 0, 4'h0, 4'hF, 1, 1);
    add(1, "sat_hold",        0, 1, 0, 0, 0, 0, 0, 4'h0, 4'hF, 0, 1);

    add(2, "bit_reset",       1, 0, 0, 0, 0, 0, 0, 4'h0, 4'h1, 0, 0);
    add(2, "bit_inr_wrap",    0, 1, 0, 0, 0, 1, 0, 4'h0, 4'h0, 1, 1);
    add(2, "bit_inr",         0, 1, 0, 0, 0, 1, 0, 4'h0, 4'h1, 0, 1);
    add(2, "bit_dcr",         0, 1, 0, 0, 0, 0, 1, 4'h0, 4'h0, 0, 1);
    add(2, "bit_dcr_wrap",    0, 1, 0, 0, 0, 0, 1, 4'h0, 4'h1, 1, 1);
    add(2, "bit_clr",         0, 1, 1, 0, 0, 0, 0, 4'h0, 4'h0, 0, 0);
    add(2, "bit_tgl",         0, 1, 0, 0, 1, 0, 0, 4'h1, 4'h1, 0, 0);

    for (int i = 0; i < vq.size(); i++) apply(vq[i]);

    // Saturating instance: reset lands on the same edge as a pinned-at-max increment.
    begin
      vec_t v;
      v.sel = 1; v.name = "sat_midwrap_reset";
      v.ctl = '{rst: 1'b1, en: 1'b1, clr: 1'b0, ld: 1'b0, tgl: 1'b0, inr: 1'b1, dcr: 1'b0, din: 4'h0};
      v.exp_out = 4'h5; v.exp_c = 1'b0; v.exp_o = 1'b0;
      apply(v);
      v.name = "sat_post_reset_dcr";
      v.ctl = '{rst: 1'b0, en: 1'b1, clr: 1'b0, ld: 1'b0, tgl: 1'b0, inr: 1'b0, dcr: 1'b1, din: 4'h0};
      v.exp_out = 4'h4;
      apply(v);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
